// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the sequential signed divider: default
//               width, FSM state encoding and special-case result constants.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

   // Default operand / result width
   localparam int DIV_WIDTH = 64;

   // FSM state encoding (2-bit, legacy-compatible)
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_FIX  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   // Special-case results at the default width
   localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES   = {DIV_WIDTH{1'b1}};
   localparam logic [DIV_WIDTH-1:0] DIV_MIN_SIGNED = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 non-restoring division iteration.
//               Shifts {partial remainder, quotient} left by one, then adds or
//               subtracts the divisor magnitude depending on the sign of the
//               current partial remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   i_pr,       // signed partial remainder (WIDTH+1 bits)
   input  logic [WIDTH-1:0] i_q,        // quotient / remaining dividend bits
   input  logic [WIDTH-1:0] i_divisor,  // divisor magnitude (unsigned)
   output logic [WIDTH:0]   o_pr,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0] w_pr_shift;
   logic [WIDTH:0] w_div_ext;

   // Single non-restoring step. Intermediate values may exceed the WIDTH+1 bit
   // range, but the final result always lies in [-D, D) so modular arithmetic
   // yields the exact value.
   always_comb begin
      w_pr_shift = {i_pr[WIDTH-1:0], i_q[WIDTH-1]};
      w_div_ext  = {1'b0, i_divisor};
      if (i_pr[WIDTH]) begin
         o_pr = w_pr_shift + w_div_ext;
      end else begin
         o_pr = w_pr_shift - w_div_ext;
      end
      o_q = {i_q[WIDTH-2:0], ~o_pr[WIDTH]};
   end

endmodule : div_step
`default_nettype wire

// File: rtl/signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : signed_divider
// Description : Sequential signed divider, one quotient bit per cycle
//               (radix-2 non-restoring). Quotient truncates toward zero and the
//               remainder takes the sign of the dividend. Shares the
//               op_start/op_clear/op_done handshake with the Booth multiplier.
//               WIDTH must be even and at least 4.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic             op_clear,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             op_done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int                CW          = $clog2(WIDTH);
   localparam logic [CW-1:0]     c_CNT_INIT  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]  c_ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]  c_MIN_SIGN  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       r_state;
   logic [WIDTH:0]   r_pr;          // signed partial remainder
   logic [WIDTH-1:0] r_q;           // working quotient (starts as |dividend|)
   logic [WIDTH-1:0] r_dvs;         // |divisor|
   logic             r_dvd_neg;
   logic             r_dvs_neg;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic [WIDTH:0]   w_pr_next;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_dvd_abs;
   logic [WIDTH-1:0] w_dvs_abs;
   logic [WIDTH-1:0] w_rem_mag;
   logic             w_div_zero;
   logic             w_overflow;

   div_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .i_pr      (r_pr),
      .i_q       (r_q),
      .i_divisor (r_dvs),
      .o_pr      (w_pr_next),
      .o_q       (w_q_next)
   );

   // Operand magnitudes, special-case detection and final remainder correction
   always_comb begin
      w_dvd_abs  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      w_dvs_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
      w_div_zero = (divisor == '0);
      w_overflow = (dividend == c_MIN_SIGN) && (divisor == c_ALL_ONES);
      // A negative partial remainder is corrected by adding the divisor back;
      // the top bit of the sum is always zero, so only the low WIDTH bits matter.
      w_rem_mag  = r_pr[WIDTH-1:0] + (r_pr[WIDTH] ? r_dvs : '0);
   end

   // Control FSM, iteration datapath and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pr        <= '0;
         r_q         <= '0;
         r_dvs       <= '0;
         r_dvd_neg   <= 1'b0;
         r_dvs_neg   <= 1'b0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (op_clear) begin
         r_state     <= ST_IDLE;
         r_pr        <= '0;
         r_q         <= '0;
         r_dvs       <= '0;
         r_dvd_neg   <= 1'b0;
         r_dvs_neg   <= 1'b0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (op_start) begin
                  r_q       <= w_dvd_abs;
                  r_dvs     <= w_dvs_abs;
                  r_dvd_neg <= dividend[WIDTH-1];
                  r_dvs_neg <= divisor[WIDTH-1];
                  r_pr      <= '0;
                  r_cnt     <= c_CNT_INIT;
                  if (w_div_zero) begin
                     r_quotient  <= c_ALL_ONES;
                     r_remainder <= dividend;
                     r_state     <= ST_DONE;
                  end else if (w_overflow) begin
                     r_quotient  <= c_MIN_SIGN;
                     r_remainder <= '0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_state <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               r_pr  <= w_pr_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_quotient  <= (r_dvd_neg ^ r_dvs_neg) ? (~r_q + 1'b1) : r_q;
               r_remainder <= r_dvd_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
               r_state     <= ST_DONE;
            end
            default: begin
               // DONE: hold results until op_clear or reset
               r_state <= ST_DONE;
            end
         endcase
      end
   end

   assign op_done   = (r_state == ST_DONE);
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule : signed_divider
`default_nettype wire
